node_ctrl: RTL
==============

// Module: node_ctrl
// PURPOSE
//  Sequencer for one MAC node. Per output node it issues: clear accumulator, stream of input
//  indices with start, pipeline drain, result capture. Loops over num_nodes output nodes, then
//  pulses done. Sits between the layer/host control and the node datapath + coef/data buffers.
// PARAMETERS
//  MAX_IN    64  max inputs per node (cnt_val range 0..MAX_IN-1)
//  CNT_W     7   width of cnt_val / num_inputs (holds 1..MAX_IN)
//  MAX_NODES 8   max output nodes per run
//  NODE_W    3   node index width (0..MAX_NODES-1)
//  PIPE_LAT  2   cycles from last start to node_out valid (>=1)
//  OUT_W     3   width of node_out / res_data
// PORTS
//  clk        in   1             system clock, all logic on rising edge
//  n_rst      in   1             synchronous active-low reset
//  go         in   1             start run; sampled only in IDLE
//  abort      in   1             cancel run; returns to IDLE next cycle
//  num_inputs in   CNT_W         inputs per node, legal 1..MAX_IN; latched on go
//  num_nodes  in   NODE_W+1      output nodes, legal 1..MAX_NODES; latched on go
//  node_out   in   OUT_W         result from node datapath
//  res_ready  in   1             consumer accepts res_data
//  start      out  1             node MAC enable, index = cnt_val
//  reset_acc  out  1             node accumulator clear
//  cnt_val    out  CNT_W         current input index
//  coef_addr  out  NODE_W+CNT_W-1  node_idx*MAX_IN + cnt_val (coef buffer address)
//  res_valid  out  1             res_data/res_node valid
//  res_node   out  NODE_W        node index of res_data
//  res_data   out  OUT_W         captured node_out
//  busy       out  1             high in every state except IDLE
//  done       out  1             1-cycle pulse after last result accepted
//  err        out  1             1-cycle pulse on go with illegal config
// BEHAVIOUR
//  - Reset (n_rst=0 at edge): state IDLE, every output 0, counters/latched config 0.
//  - States: IDLE, CLEAR, ACCUM, DRAIN, CAPTURE, DONE.
//  - IDLE: go=1 & legal config -> latch config, node_idx=0, go CLEAR. Illegal (num_inputs=0 or
//    >MAX_IN, num_nodes=0 or >MAX_NODES) -> err=1 next cycle, stay IDLE.
//  - CLEAR: reset_acc=1, start=0, 1 cycle -> ACCUM with cnt=0.
//  - ACCUM: start=1, cnt_val=cnt, coef_addr tracks; cnt increments each cycle; at cnt==num_inputs-1
//    -> DRAIN (exactly num_inputs start cycles, indices 0..N-1 in order).
//  - DRAIN: start=0, cnt_val holds last index, PIPE_LAT cycles -> CAPTURE.
//  - CAPTURE: on entry register node_out->res_data, node_idx->res_node; res_valid=1, held stable
//    until res_ready=1. Handshake completes in cycle with res_valid&res_ready; res_valid drops next
//    cycle. Then node_idx==num_nodes-1 -> DONE, else node_idx++ -> CLEAR.
//  - DONE: done=1 for one cycle -> IDLE. Back-to-back go accepted in the IDLE cycle after DONE.
//  - Latency per node with res_ready tied 1: 1+N+PIPE_LAT+1 cycles; run = nodes*that + 1 (DONE).
//  - abort=1 in any non-IDLE state: next state IDLE, outputs cleared, no done. abort and go both
//    high in IDLE: abort wins, go ignored.
//  - go while busy: ignored; config inputs changing mid-run: no effect.
//  - n_rst low mid-run: synchronous return to IDLE on that edge, identical to power-up reset.
//  - Widths: coef_addr = {node_idx, cnt[CNT_W-2:0]}; all counters unsigned, no wrap beyond config.
// STRUCTURE
//  - Shared package node_pkg: state enum node_ctrl_state_t, MAX_IN, MAX_NODES, CNT_W, NODE_W.
//  - One sub-module: node_ctrl_cnt (loadable up-counter w/ clear, enable, rollover-at-value flag),
//    instanced for cnt and for DRAIN timer; node_idx counter inline.
// TESTING
//  1 Reset: n_rst=0 for 2 cycles mid-ACCUM -> all outputs 0, state IDLE, busy=0 next cycle.
//  2 go, N=3, nodes=2, PIPE_LAT=2, res_ready=1 -> per node: reset_acc 1 cyc, start 3 cyc cnt 0,1,2,
//    coef_addr 0,1,2 then 64,65,66; res_node 0 then 1; done at cycle 15 after go.
//  3 Backpressure: res_ready=0 for 5 cycles in CAPTURE -> res_valid,res_data stable, no advance.
//  4 Illegal config: go with num_inputs=0, then num_nodes=9 -> err pulse each, busy stays 0.
//  5 abort during DRAIN, also go&abort in IDLE -> IDLE next cycle, no done, go ignored.
//  6 Edge: N=64, nodes=8 -> cnt_val reaches 63, coef_addr max 511, done after 8 results.

Source files
------------

// File: rtl/node_pkg.sv
// Shared types and sizing for the MAC node sequencer.
package node_pkg;

  localparam int MAX_IN    = 64;
  localparam int CNT_W     = 7;
  localparam int MAX_NODES = 8;
  localparam int NODE_W    = 3;
  localparam int PIPE_LAT  = 2;
  localparam int OUT_W     = 3;

  // Drain timer only needs to count 0..PIPE_LAT-1.
  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_CAPTURE,
    ST_DONE
  } node_ctrl_state_t;

endpackage

// File: rtl/node_ctrl_cnt.sv
// Loadable up-counter with clear, enable and a terminal-value flag.
// Rolls over to zero when enabled while sitting at last_val.
module node_ctrl_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last_val,
  output logic [W-1:0] cnt,
  output logic         at_last
);

  assign at_last = (cnt == last_val);

  // Count register: clear beats load beats increment.
  always_ff @(posedge clk) begin
    if (!n_rst)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= at_last ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/node_ctrl.sv
// Sequencer for one MAC node: per output node it clears the accumulator,
// streams input indices, waits out the datapath pipeline and hands the
// result to the consumer; loops over all nodes then pulses done.
//
// state   | meaning
// IDLE    | waiting for go, outputs quiet
// CLEAR   | one cycle of accumulator clear
// ACCUM   | start high, cnt_val walks 0..num_inputs-1
// DRAIN   | PIPE_LAT cycles for the last product to reach node_out
// CAPTURE | res_valid high with registered result until res_ready
// DONE    | one-cycle done pulse
module node_ctrl
  import node_pkg::*;
(
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      go,
  input  logic                      abort,
  input  logic [CNT_W-1:0]          num_inputs,
  input  logic [NODE_W:0]           num_nodes,
  input  logic [OUT_W-1:0]          node_out,
  input  logic                      res_ready,
  output logic                      start,
  output logic                      reset_acc,
  output logic [CNT_W-1:0]          cnt_val,
  output logic [NODE_W+CNT_W-2:0]   coef_addr,
  output logic                      res_valid,
  output logic [NODE_W-1:0]         res_node,
  output logic [OUT_W-1:0]          res_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  node_ctrl_state_t state, state_nxt;

  logic [CNT_W-1:0]  num_in_q;
  logic [NODE_W:0]   num_nodes_q;
  logic [NODE_W-1:0] node_idx;
  logic [NODE_W-1:0] res_node_q;
  logic [OUT_W-1:0]  res_data_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;
  logic [DRN_W-1:0]  drn_cnt;
  logic              drn_last;
  logic              cfg_ok;
  logic              node_last;

  assign cfg_ok = (num_inputs != '0) && (num_inputs <= CNT_W'(MAX_IN)) &&
                  (num_nodes != '0) && (num_nodes <= (NODE_W+1)'(MAX_NODES));

  assign node_last = (({1'b0, node_idx} + (NODE_W+1)'(1)) == num_nodes_q);

  // Input index: zeroed in CLEAR, stops on the last index so DRAIN shows it.
  node_ctrl_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (state == ST_IDLE),
    .load     (state == ST_CLEAR),
    .load_val ('0),
    .en       ((state == ST_ACCUM) && !cnt_last),
    .last_val (num_in_q - CNT_W'(1)),
    .cnt      (cnt),
    .at_last  (cnt_last)
  );

  node_ctrl_cnt #(.W(DRN_W)) u_drn (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (state != ST_DRAIN),
    .load     (1'b0),
    .load_val ('0),
    .en       (state == ST_DRAIN),
    .last_val (DRN_W'(PIPE_LAT - 1)),
    .cnt      (drn_cnt),
    .at_last  (drn_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt = state;
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (go && !abort && cfg_ok) state_nxt = ST_CLEAR;
        ST_CLEAR:   state_nxt = ST_ACCUM;
        ST_ACCUM:   if (cnt_last) state_nxt = ST_DRAIN;
        ST_DRAIN:   if (drn_last) state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (res_ready) state_nxt = node_last ? ST_DONE : ST_CLEAR;
        ST_DONE:    state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Config latch, node index, result capture and the error pulse.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      num_in_q    <= '0;
      num_nodes_q <= '0;
      node_idx    <= '0;
      res_node_q  <= '0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= (state == ST_IDLE) && go && !abort && !cfg_ok;
      if ((state == ST_IDLE) && (state_nxt == ST_CLEAR)) begin
        num_in_q    <= num_inputs;
        num_nodes_q <= num_nodes;
        node_idx    <= '0;
      end else if ((state == ST_CAPTURE) && (state_nxt == ST_CLEAR)) begin
        node_idx <= node_idx + NODE_W'(1);
      end
      if ((state == ST_DRAIN) && (state_nxt == ST_CAPTURE)) begin
        res_data_q <= node_out;
        res_node_q <= node_idx;
      end
    end
  end

  // Outputs decoded from state; index and result buses read zero when unused.
  always_comb begin
    start     = 1'b0;
    reset_acc = 1'b0;
    cnt_val   = '0;
    coef_addr = '0;
    res_valid = 1'b0;
    res_node  = '0;
    res_data  = '0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    err       = err_q;
    case (state)
      ST_CLEAR: reset_acc = 1'b1;
      ST_ACCUM: begin
        start     = 1'b1;
        cnt_val   = cnt;
        coef_addr = {node_idx, cnt[CNT_W-2:0]};
      end
      ST_DRAIN: begin
        cnt_val   = cnt;
        coef_addr = {node_idx, cnt[CNT_W-2:0]};
      end
      ST_CAPTURE: begin
        res_valid = 1'b1;
        res_node  = res_node_q;
        res_data  = res_data_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
